// File: rtl/gustavson_pkg.sv
// rtl/gustavson_pkg.sv - shared types and default sizing for the Gustavson sequencer
package gustavson_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SCAN, EMIT, DONE} state_t;

   localparam int N_DEF         = 3;
   localparam int DW_DEF        = 8;
   localparam int AW_DEF        = 4;
   localparam int ADDR_BASE_DEF = 1;

   typedef logic [DW_DEF-1:0] elem_t;

endpackage

// File: rtl/gustavson_row_mac.sv
// rtl/gustavson_row_mac.sv - N parallel wrapping multiply-accumulate lanes sharing one scalar
module gustavson_row_mac #(
   parameter int N  = 3,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clear,
   input  logic            i_en,
   input  logic [DW-1:0]   i_a,
   input  logic [N*DW-1:0] i_b,
   output logic [N*DW-1:0] o_acc
);

   for (genvar k = 0; k < N; k++) begin : g_lane
      logic [DW-1:0]   r_acc;
      logic [2*DW-1:0] w_prod;

      // only the low DW bits of the product feed the accumulator
      assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b[k*DW +: DW]};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_acc <= '0;
         end else if (i_clear) begin
            r_acc <= '0;
         end else if (i_en) begin
            r_acc <= r_acc + w_prod[DW-1:0];
         end
      end

      assign o_acc[k*DW +: DW] = r_acc;
   end

endmodule

// File: rtl/gustavson_seq_ctrl.sv
// rtl/gustavson_seq_ctrl.sv - start/done sequencer for row-wise sparse C = A x B
module gustavson_seq_ctrl
   import gustavson_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int DW        = DW_DEF,
   parameter int AW        = AW_DEF,
   parameter int ADDR_BASE = ADDR_BASE_DEF,
   localparam int RW       = (N > 1) ? $clog2(N) : 1,
   localparam int KW       = $clog2(N*N+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   output logic [AW-1:0] o_mem_a_addr,
   output logic [AW-1:0] o_mem_b_addr,
   output logic          o_mem_en,
   input  logic [DW-1:0] i_mem_a_dout,
   input  logic [DW-1:0] i_mem_b_dout,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic [DW-1:0] o_res_data,
   output logic [RW-1:0] o_res_row,
   output logic [RW-1:0] o_res_col,
   output logic [KW-1:0] o_nz_count
);

   state_t          r_state, w_state;
   logic [KW-1:0]   r_k;
   logic [RW-1:0]   r_lr, r_lc, r_i, r_c;
   logic [N-1:0]    r_vis;
   logic [KW-1:0]   r_nz;
   logic [DW-1:0]   r_a [N][N];
   logic [DW-1:0]   r_b [N][N];

   logic [N-1:0]    w_mask, w_rem, w_rem_left;
   logic            w_found;
   logic [RW-1:0]   w_j;
   logic [DW-1:0]   w_a;
   logic [N*DW-1:0] w_b, w_acc;
   logic            w_clear, w_en;
   logic            w_load_end, w_row_last, w_col_last;

   assign w_load_end = (r_k == KW'(N*N));
   assign w_row_last = (r_i == RW'(N-1));
   assign w_col_last = (r_c == RW'(N-1));

   // lowest unvisited non-zero column of row i, plus the operands it selects
   always_comb begin
      w_mask = '0;
      for (int j = 0; j < N; j++) begin
         w_mask[j] = (r_a[r_i][j] != '0);
      end
      w_rem   = w_mask & ~r_vis;
      w_found = 1'b0;
      w_j     = '0;
      for (int j = N-1; j >= 0; j--) begin
         if (w_rem[j]) begin
            w_found = 1'b1;
            w_j     = RW'(j);
         end
      end
      w_rem_left      = w_rem;
      w_rem_left[w_j] = 1'b0;
      w_a             = r_a[r_i][w_j];
      w_b             = '0;
      for (int k = 0; k < N; k++) begin
         w_b[k*DW +: DW] = r_b[w_j][k];
      end
   end

   assign w_en    = (r_state == SCAN) && w_found;
   assign w_clear = ((r_state == LOAD) && w_load_end) ||
                    ((r_state == EMIT) && i_res_ready && w_col_last && !w_row_last);

   gustavson_row_mac #(.N(N), .DW(DW)) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_en    (w_en),
      .i_a     (w_a),
      .i_b     (w_b),
      .o_acc   (w_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   always_comb begin
      w_state      = r_state;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      o_mem_en     = 1'b0;
      o_mem_a_addr = '0;
      o_mem_b_addr = '0;
      o_res_valid  = 1'b0;
      o_res_data   = '0;
      o_res_row    = '0;
      o_res_col    = '0;
      case (r_state)
         IDLE: begin
            if (i_start) w_state = LOAD;
         end
         LOAD: begin
            o_busy = 1'b1;
            if (!w_load_end) begin
               o_mem_en     = 1'b1;
               o_mem_a_addr = AW'(ADDR_BASE) + AW'(r_k);
               o_mem_b_addr = AW'(ADDR_BASE) + AW'(r_k);
            end else begin
               w_state = SCAN;
            end
         end
         SCAN: begin
            o_busy = 1'b1;
            if (!w_found || (w_rem_left == '0)) w_state = EMIT;
         end
         EMIT: begin
            o_busy      = 1'b1;
            o_res_valid = 1'b1;
            o_res_row   = r_i;
            o_res_col   = r_c;
            for (int k = 0; k < N; k++) begin
               if (RW'(k) == r_c) o_res_data = w_acc[k*DW +: DW];
            end
            if (i_res_ready && w_col_last) w_state = w_row_last ? DONE : SCAN;
         end
         DONE: begin
            o_done  = 1'b1;
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

   // r_lr/r_lc trail the issued address by one cycle to match read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k   <= '0;
         r_lr  <= '0;
         r_lc  <= '0;
         r_i   <= '0;
         r_c   <= '0;
         r_vis <= '0;
         r_nz  <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_a[r][c] <= '0;
               r_b[r][c] <= '0;
            end
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_k  <= '0;
                  r_lr <= '0;
                  r_lc <= '0;
                  r_nz <= '0;
               end
            end
            LOAD: begin
               if (r_k != '0) begin
                  r_a[r_lr][r_lc] <= i_mem_a_dout;
                  r_b[r_lr][r_lc] <= i_mem_b_dout;
                  if (i_mem_a_dout != '0) r_nz <= r_nz + KW'(1);
                  if (r_lc == RW'(N-1)) begin
                     r_lc <= '0;
                     r_lr <= r_lr + RW'(1);
                  end else begin
                     r_lc <= r_lc + RW'(1);
                  end
               end
               if (w_load_end) begin
                  r_i   <= '0;
                  r_vis <= '0;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            SCAN: begin
               r_c <= '0;
               if (w_found) r_vis[w_j] <= 1'b1;
            end
            EMIT: begin
               if (i_res_ready) begin
                  if (w_col_last) begin
                     r_c <= '0;
                     if (!w_row_last) begin
                        r_i   <= r_i + RW'(1);
                        r_vis <= '0;
                     end
                  end else begin
                     r_c <= r_c + RW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_nz_count = r_nz;

endmodule

// File: tb/tb_gustavson_seq_ctrl.sv
// tb/tb_gustavson_seq_ctrl.sv - scoreboard bench for gustavson_seq_ctrl
module tb_gustavson_seq_ctrl;
   import gustavson_pkg::*;

   localparam int N  = 3;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int AB = 1;

   logic          clk, rst_n, start, busy, done, mem_en;
   logic [AW-1:0] mem_a_addr, mem_b_addr;
   logic [DW-1:0] mem_a_dout, mem_b_dout, res_data;
   logic          res_valid, res_ready;
   logic [1:0]    res_row, res_col;
   logic [3:0]    nz_count;

   gustavson_seq_ctrl #(.N(N), .DW(DW), .AW(AW), .ADDR_BASE(AB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (start),
      .o_busy       (busy),
      .o_done       (done),
      .o_mem_a_addr (mem_a_addr),
      .o_mem_b_addr (mem_b_addr),
      .o_mem_en     (mem_en),
      .i_mem_a_dout (mem_a_dout),
      .i_mem_b_dout (mem_b_dout),
      .o_res_valid  (res_valid),
      .i_res_ready  (res_ready),
      .o_res_data   (res_data),
      .o_res_row    (res_row),
      .o_res_col    (res_col),
      .o_nz_count   (nz_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   elem_t mem_a [16];
   elem_t mem_b [16];

   always @(posedge clk) begin
      if (mem_en) begin
         mem_a_dout <= mem_a[mem_a_addr];
         mem_b_dout <= mem_b[mem_b_addr];
      end
   end

   typedef struct {
      logic [7:0] d;
      logic [1:0] r;
      logic [1:0] c;
   } exp_t;

   exp_t sb [$];
   int   a_m [N][N];
   int   b_m [N][N];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic load_mem();
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'hEE;
         mem_b[i] = 8'hDD;
      end
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            mem_a[AB + r*N + c] = elem_t'(a_m[r][c]);
            mem_b[AB + r*N + c] = elem_t'(b_m[r][c]);
         end
      end
   endtask

   task automatic push_expected(output int nz, output int lat);
      exp_t e;
      int   s, rn;
      nz  = 0;
      lat = 1 + (N*N + 1) + 1;
      for (int r = 0; r < N; r++) begin
         rn = 0;
         for (int j = 0; j < N; j++) if (a_m[r][j] != 0) rn++;
         nz  += rn;
         lat += ((rn > 1) ? rn : 1) + N;
         for (int c = 0; c < N; c++) begin
            s = 0;
            for (int j = 0; j < N; j++) s += a_m[r][j] * b_m[j][c];
            e.d = 8'(s & 255);
            e.r = 2'(r);
            e.c = 2'(c);
            sb.push_back(e);
         end
      end
   endtask

   // caller is at a negedge; start is raised for the next active edge
   task automatic run_job(input string name, input bit stall, input bit poke);
      int   nz_exp, lat_exp, cyc, n_mem;
      bit   stalled, finished, rdy;
      exp_t held, e;
      load_mem();
      push_expected(nz_exp, lat_exp);
      start    = 1'b1;
      cyc      = 1;
      n_mem    = 0;
      stalled  = 1'b0;
      finished = 1'b0;
      while (!finished && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         rdy       = stall ? ((cyc % 3) == 0) : 1'b1;
         res_ready = rdy;
         if (mem_en) begin
            n_checks++;
            if (mem_a_addr !== AW'(AB + n_mem) || mem_b_addr !== AW'(AB + n_mem)) begin
               n_fail++;
               $display("FAIL %s addr: got a=%0d b=%0d exp %0d", name, mem_a_addr, mem_b_addr, AB + n_mem);
            end
            n_mem++;
         end
         if (res_valid) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s valid_busy: busy=%0b exp 1", name, busy);
            end
            if (stalled) begin
               n_checks++;
               if (res_data !== held.d || res_row !== held.r || res_col !== held.c) begin
                  n_fail++;
                  $display("FAIL %s stable: got %0d@(%0d,%0d) exp %0d@(%0d,%0d)", name,
                           res_data, res_row, res_col, held.d, held.r, held.c);
               end
            end
            if (rdy) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL %s extra: got %0d@(%0d,%0d) exp none", name, res_data, res_row, res_col);
               end else begin
                  e = sb.pop_front();
                  if (res_data !== e.d || res_row !== e.r || res_col !== e.c) begin
                     n_fail++;
                     $display("FAIL %s result: got %0d@(%0d,%0d) exp %0d@(%0d,%0d)", name,
                              res_data, res_row, res_col, e.d, e.r, e.c);
                  end
               end
            end
            stalled = !rdy;
            held.d  = res_data;
            held.r  = res_row;
            held.c  = res_col;
         end else begin
            stalled = 1'b0;
         end
         if (done) begin
            start    = 1'b0;
            finished = 1'b1;
            n_checks++;
            if (nz_count !== 4'(nz_exp)) begin
               n_fail++;
               $display("FAIL %s nz_count: got %0d exp %0d", name, nz_count, nz_exp);
            end
            n_checks++;
            if (sb.size() != 0 || n_mem != N*N || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL %s drain: left %0d reads %0d busy %0b exp 0 %0d 0", name, sb.size(), n_mem, busy, N*N);
            end
            if (!stall) begin
               n_checks++;
               if (cyc != lat_exp) begin
                  n_fail++;
                  $display("FAIL %s latency: got %0d exp %0d", name, cyc, lat_exp);
               end
            end
         end
      end
      start     = 1'b0;
      res_ready = 1'b1;
      if (!finished) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: done not seen in %0d cycles exp %0d", name, cyc, lat_exp);
         sb.delete();
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || nz_count !== 4'(nz_exp)) begin
         n_fail++;
         $display("FAIL %s after_done: done=%0b busy=%0b valid=%0b nz=%0d exp 0 0 0 %0d",
                  name, done, busy, res_valid, nz_count, nz_exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_en !== 1'b0 || res_valid !== 1'b0 ||
          mem_a_addr !== '0 || mem_b_addr !== '0 || res_data !== '0 ||
          res_row !== '0 || res_col !== '0 || nz_count !== '0) begin
         n_fail++;
         $display("FAIL %s reset_vals: busy=%0b done=%0b en=%0b valid=%0b aa=%0d ba=%0d d=%0d r=%0d c=%0d nz=%0d exp all 0",
                  name, busy, done, mem_en, res_valid, mem_a_addr, mem_b_addr, res_data, res_row, res_col, nz_count);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[r][c] = (r == c) ? 1 : 0;
            b_m[r][c] = r*N + c + 1;
         end
      run_job("identity", 1'b0, 1'b0);
   endtask

   task automatic test_zero();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[r][c] = 0;
            b_m[r][c] = int'($urandom_range(0, 255));
         end
      run_job("zero_a", 1'b0, 1'b0);
   endtask

   task automatic test_ones();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[r][c] = 1;
            b_m[r][c] = 1;
         end
      run_job("all_ones", 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[r][c] = 0;
            b_m[r][c] = 0;
         end
      a_m[0][0] = 20;
      b_m[0][0] = 13;
      b_m[0][1] = 26;
      b_m[0][2] = 255;
      run_job("wrap", 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[r][c] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 255));
            b_m[r][c] = int'($urandom_range(0, 255));
         end
      a_m[1][0] = 0;
      a_m[1][2] = 7;
      run_job("backpressure", 1'b1, 1'b1);
   endtask

   task automatic test_mid_reset();
      int got, guard;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[r][c] = r + c + 1;
            b_m[r][c] = 2*r + c + 3;
         end
      load_mem();
      start = 1'b1;
      got   = 0;
      guard = 0;
      while (got < N && guard < 200) begin
         @(negedge clk);
         start = 1'b0;
         guard++;
         if (res_valid) got++;
      end
      @(negedge clk);
      n_checks++;
      if (got != N || busy !== 1'b1 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset reach_scan: rows0=%0d busy=%0b valid=%0b exp %0d 1 0", got, busy, res_valid, N);
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_job("post_reset", 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_identity();
      test_zero();
      test_ones();
      test_wrap();
      test_backpressure();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
